// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the extension unit: mode codes, address-width
// derivation and the misalignment rule used by the datapath.
package ext_pipe_pkg;

  typedef enum logic [2:0] {
    EXT_ZERO = 3'd0,
    EXT_SIGN = 3'd1,
    EXT_LUI  = 3'd2,
    EXT_LB   = 3'd3,
    EXT_LBU  = 3'd4,
    EXT_LH   = 3'd5,
    EXT_LHU  = 3'd6,
    EXT_LW   = 3'd7
  } ext_mode_e;

  // Byte-offset width for a memory word of dw bits.
  function automatic int ext_aw(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Halfword loads need an even offset, word loads a multiple of four.
  // Immediate and byte modes can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if ((mode == EXT_LH || mode == EXT_LHU) && lo[0])
      bad = 1'b1;
    if (mode == EXT_LW && lo != 2'b00)
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ext_pipe_core.sv
// Combinational extension datapath: mode decode, byte-lane selection,
// zero/sign extension and misalignment detection.
module ext_core
  import ext_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int AW = ext_aw(DATA_WIDTH)
) (
  input  logic [2:0]            mode,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [AW-1:0]         addr_lo,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int NH = DATA_WIDTH / 16;
  localparam int NW = DATA_WIDTH / 32;

  logic [IMM_WIDTH-1:0]  imm;
  logic [DATA_WIDTH-1:0] lui_wide;
  logic [31:0]           lui32;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           lane_w;
  int                    byte_i;
  int                    half_i;
  int                    word_i;

  // Pick the addressed lanes, extend according to the mode and force the
  // result to zero whenever the access is misaligned.
  always_comb begin
    imm      = data[IMM_WIDTH-1:0];
    lui_wide = DATA_WIDTH'(imm) << 16;
    lui32    = lui_wide[31:0];
    byte_i   = int'(addr_lo);
    half_i   = byte_i >> 1;
    word_i   = byte_i >> 2;
    if (BIG_ENDIAN) begin
      byte_i = NB - 1 - byte_i;
      half_i = NH - 1 - half_i;
      word_i = NW - 1 - word_i;
    end
    lane_b = data[8*byte_i +: 8];
    lane_h = data[16*half_i +: 16];
    lane_w = data[32*word_i +: 32];
    err    = is_misaligned(mode, addr_lo[1:0]);
    result = '0;
    case (mode)
      EXT_ZERO: result = DATA_WIDTH'(imm);
      EXT_SIGN: result = DATA_WIDTH'($signed(imm));
      EXT_LUI:  result = DATA_WIDTH'($signed(lui32));
      EXT_LB:   result = DATA_WIDTH'($signed(lane_b));
      EXT_LBU:  result = DATA_WIDTH'(lane_b);
      EXT_LH:   result = DATA_WIDTH'($signed(lane_h));
      EXT_LHU:  result = DATA_WIDTH'(lane_h);
      EXT_LW:   result = DATA_WIDTH'($signed(lane_w));
      default:  result = '0;
    endcase
    if (err)
      result = '0;
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered extension unit: one ext_core in front of an output register
// plus a one-entry skid register so in_ready never depends on out_ready
// combinationally while still sustaining one result per cycle.
module ext_pipe
  import ext_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int AW = ext_aw(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [AW-1:0]         in_addr_lo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_err;

  logic                  or_valid;
  logic [DATA_WIDTH-1:0] or_data;
  logic                  or_err;
  logic                  sk_valid;
  logic [DATA_WIDTH-1:0] sk_data;
  logic                  sk_err;
  logic                  ready_q;

  logic take_in;
  logic take_out;
  logic or_load_in;
  logic or_load_sk;
  logic sk_load;
  logic or_valid_nxt;
  logic sk_valid_nxt;

  ext_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_core (
    .mode    (in_mode),
    .data    (in_data),
    .addr_lo (in_addr_lo),
    .result  (core_data),
    .err     (core_err)
  );

  assign in_ready  = ready_q;
  assign out_valid = or_valid;
  assign out_data  = or_data;
  assign out_err   = or_err;

  // Decide where this cycle's data goes: a full skid drains into OR first,
  // otherwise new results land in OR when it frees up, else in the skid.
  always_comb begin
    take_in      = in_valid && ready_q;
    take_out     = or_valid && out_ready;
    or_load_in   = 1'b0;
    or_load_sk   = 1'b0;
    sk_load      = 1'b0;
    or_valid_nxt = or_valid;
    sk_valid_nxt = sk_valid;
    if (sk_valid) begin
      if (take_out) begin
        or_load_sk   = 1'b1;
        sk_valid_nxt = 1'b0;
      end
    end else if (!or_valid || take_out) begin
      or_valid_nxt = take_in;
      or_load_in   = take_in;
    end else if (take_in) begin
      sk_load      = 1'b1;
      sk_valid_nxt = 1'b1;
    end
  end

  // Output and skid registers; in_ready is held low through reset and
  // follows the next skid occupancy afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      or_err   <= 1'b0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
      sk_err   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      or_valid <= or_valid_nxt;
      sk_valid <= sk_valid_nxt;
      ready_q  <= !sk_valid_nxt;
      if (or_load_in) begin
        or_data <= core_data;
        or_err  <= core_err;
      end else if (or_load_sk) begin
        or_data <= sk_data;
        or_err  <= sk_err;
      end
      if (sk_load) begin
        sk_data <= core_data;
        sk_err  <= core_err;
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe: immediate and load extension,
// misalignment, backpressure, throughput, async reset, big-endian and 64-bit.
module tb_ext_pipe;

  localparam logic [2:0] M_ZERO = 3'd0;
  localparam logic [2:0] M_SIGN = 3'd1;
  localparam logic [2:0] M_LUI  = 3'd2;
  localparam logic [2:0] M_LB   = 3'd3;
  localparam logic [2:0] M_LBU  = 3'd4;
  localparam logic [2:0] M_LH   = 3'd5;
  localparam logic [2:0] M_LHU  = 3'd6;
  localparam logic [2:0] M_LW   = 3'd7;

  logic        clk;
  logic        reset;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_data;
  logic [1:0]  in_addr_lo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  logic        be_in_valid;
  logic        be_in_ready;
  logic [2:0]  be_in_mode;
  logic [31:0] be_in_data;
  logic [1:0]  be_in_addr_lo;
  logic        be_out_valid;
  logic        be_out_ready;
  logic [31:0] be_out_data;
  logic        be_out_err;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [2:0]  w_in_mode;
  logic [63:0] w_in_data;
  logic [2:0]  w_in_addr_lo;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_out_data;
  logic        w_out_err;

  int errors = 0;
  int checks = 0;

  ext_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_addr_lo(in_addr_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  ext_pipe #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset),
    .in_valid(be_in_valid), .in_ready(be_in_ready), .in_mode(be_in_mode),
    .in_data(be_in_data), .in_addr_lo(be_in_addr_lo),
    .out_valid(be_out_valid), .out_ready(be_out_ready),
    .out_data(be_out_data), .out_err(be_out_err)
  );

  ext_pipe #(.DATA_WIDTH(64)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode),
    .in_data(w_in_data), .in_addr_lo(w_in_addr_lo),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_err(w_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request to the main DUT, wait (bounded) for the accept and
  // return just after the accepting edge, when the result should be visible.
  task automatic applyStimulus(input logic [2:0] mode, input logic [31:0] data, input logic [1:0] addr);
    int n;
    @(negedge clk);
    in_valid   = 1'b1;
    in_mode    = mode;
    in_data    = data;
    in_addr_lo = addr;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20)
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [2:0] mode, input logic [31:0] data,
                           input logic [1:0] addr, input logic [31:0] exp_data, input logic exp_err);
    applyStimulus(mode, data, addr);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_data"}, 64'(out_data), 64'(exp_data));
    checkOutput({tag, "_err"}, 64'(out_err), 64'(exp_err));
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_mode = 3'd0; in_data = '0; in_addr_lo = '0; out_ready = 1'b1;
    be_in_valid = 1'b0; be_in_mode = 3'd0; be_in_data = '0; be_in_addr_lo = '0; be_out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_mode = 3'd0; w_in_data = '0; w_in_addr_lo = '0; w_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_err", 64'(out_err), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Immediate modes
    runVector("imm_zero", M_ZERO, 32'hABCD8001, 2'd0, 32'h00008001, 1'b0);
    runVector("imm_sign", M_SIGN, 32'hABCD8001, 2'd0, 32'hFFFF8001, 1'b0);
    runVector("imm_lui",  M_LUI,  32'hABCD8001, 2'd0, 32'h80010000, 1'b0);

    // Loads, little-endian
    runVector("ld_lb2",  M_LB,  32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
    runVector("ld_lbu3", M_LBU, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0);
    runVector("ld_lb0",  M_LB,  32'h80FF7F01, 2'd0, 32'h00000001, 1'b0);
    runVector("ld_lh0",  M_LH,  32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0);
    runVector("ld_lhu2", M_LHU, 32'h80FF7F01, 2'd2, 32'h000080FF, 1'b0);
    runVector("ld_lh2",  M_LH,  32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
    runVector("ld_lw0",  M_LW,  32'h80FF7F01, 2'd0, 32'h80FF7F01, 1'b0);

    // Misalignment
    runVector("mis_lh1",   M_LH,   32'h80FF7F01, 2'd1, 32'h00000000, 1'b1);
    runVector("mis_lw2",   M_LW,   32'h80FF7F01, 2'd2, 32'h00000000, 1'b1);
    runVector("mis_sign3", M_SIGN, 32'hABCD8001, 2'd3, 32'hFFFF8001, 1'b0);

    // Backpressure: drain, then stall the output for three edges
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = M_ZERO; in_addr_lo = 2'd0; in_data = 32'd1;
    checkOutput("bp_ready0", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("bp_valid1", 64'(out_valid), 64'd1);
    checkOutput("bp_data1", 64'(out_data), 64'd1);
    checkOutput("bp_ready1", 64'(in_ready), 64'd1);
    in_data = 32'd2;
    @(negedge clk);
    checkOutput("bp_ready2", 64'(in_ready), 64'd0);
    checkOutput("bp_stable2", 64'(out_data), 64'd1);
    checkOutput("bp_valid2", 64'(out_valid), 64'd1);
    in_data = 32'd3;
    @(negedge clk);
    checkOutput("bp_ready3", 64'(in_ready), 64'd0);
    checkOutput("bp_stable3", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_data_2", 64'(out_data), 64'd2);
    checkOutput("bp_ready4", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("bp_data_3", 64'(out_data), 64'd3);
    in_data = 32'd4;
    @(negedge clk);
    checkOutput("bp_data_4", 64'(out_data), 64'd4);
    checkOutput("bp_valid_4", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_empty", 64'(out_valid), 64'd0);

    // Back-to-back throughput
    in_valid = 1'b1; in_mode = M_ZERO;
    for (int k = 0; k < 16; k++) begin
      in_data = 32'h10 + 32'(k);
      checkOutput("tp_ready", 64'(in_ready), 64'd1);
      if (k > 0) begin
        checkOutput("tp_valid", 64'(out_valid), 64'd1);
        checkOutput("tp_data", 64'(out_data), 64'(32'h10 + 32'(k) - 32'd1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("tp_last_valid", 64'(out_valid), 64'd1);
    checkOutput("tp_last_data", 64'(out_data), 64'h1F);
    @(negedge clk);

    // Async reset with OR and SK both full
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = M_ZERO; in_data = 32'hAAAA;
    @(negedge clk);
    in_data = 32'hBBBB;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rs_full_ready", 64'(in_ready), 64'd0);
    checkOutput("rs_full_data", 64'(out_data), 64'h0000AAAA);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rs_async_valid", 64'(out_valid), 64'd0);
    checkOutput("rs_async_data", 64'(out_data), 64'd0);
    checkOutput("rs_async_err", 64'(out_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rs_ready_after", 64'(in_ready), 64'd1);
    checkOutput("rs_valid_after", 64'(out_valid), 64'd0);
    runVector("rs_next", M_SIGN, 32'h00007FFF, 2'd0, 32'h00007FFF, 1'b0);

    // Big-endian lane order
    @(negedge clk);
    be_in_valid = 1'b1; be_in_mode = M_LBU; be_in_data = 32'h80FF7F01; be_in_addr_lo = 2'd0;
    checkOutput("be_ready", 64'(be_in_ready), 64'd1);
    @(posedge clk);
    #1;
    be_in_valid = 1'b0;
    checkOutput("be_lbu0_valid", 64'(be_out_valid), 64'd1);
    checkOutput("be_lbu0_data", 64'(be_out_data), 64'h00000080);

    // 64-bit datapath
    @(negedge clk);
    w_in_valid = 1'b1; w_in_mode = M_LW; w_in_data = 64'h8000_0000_0000_0001; w_in_addr_lo = 3'd4;
    checkOutput("w_ready", 64'(w_in_ready), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("w_lw4_valid", 64'(w_out_valid), 64'd1);
    checkOutput("w_lw4_data", w_out_data, 64'hFFFFFFFF80000000);
    checkOutput("w_lw4_err", 64'(w_out_err), 64'd0);
    @(negedge clk);
    w_in_mode = M_LH; w_in_addr_lo = 3'd6;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    checkOutput("w_lh6_data", w_out_data, 64'hFFFFFFFFFFFF8000);
    checkOutput("w_lh6_err", 64'(w_out_err), 64'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Registered, parametrised extension unit for the multi-cycle datapath.
- Covers immediate extension (zero, sign, LUI) and load-data extension (LB/LBU/LH/LHU/LW) with byte-lane selection and misalignment detection.
- Sits between the memory data register / instruction register and the ALU/register-file write mux.
- Valid/ready handshake on both sides, 1-cycle latency, full throughput via a 1-entry skid buffer.

Parameters:
- DATA_WIDTH, 32, output and memory word width; legal values 32 or 64.
- IMM_WIDTH, 16, immediate field width for modes ZERO/SIGN/LUI; must be < DATA_WIDTH.
- BIG_ENDIAN, 0, byte-lane order: 0 = lane k at bits [8k+7:8k]; 1 = lane index inverted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_mode  in  3  operation code (see Behaviour).
- in_data  in  DATA_WIDTH  memory word (load modes) or immediate in bits [IMM_WIDTH-1:0] (imm modes).
- in_addr_lo  in  AW  byte offset within the word; AW = log2(DATA_WIDTH/8).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_WIDTH  extended result.
- out_err  out  1  misaligned access flag, qualified by out_valid.

Behaviour:
- Modes:
  - 0 ZERO: zero-extend in_data[IMM_WIDTH-1:0].
  - 1 SIGN: sign-extend in_data[IMM_WIDTH-1:0].
  - 2 LUI: immediate shifted left by 16, low 16 bits zero, sign-extended above bit 31 when DATA_WIDTH=64.
  - 3 LB / 4 LBU: byte lane in_addr_lo, sign- or zero-extended.
  - 5 LH / 6 LHU: halfword lane in_addr_lo[AW-1:1], sign- or zero-extended.
  - 7 LW: 32-bit lane (whole word when DATA_WIDTH=32); sign-extended when DATA_WIDTH=64.
- Lane index = in_addr_lo when BIG_ENDIAN=0; otherwise (lane count-1) - index.
- Misalignment:
  - LH/LHU with in_addr_lo[0]=1 is misaligned.
  - LW with in_addr_lo[1:0]!=0 is misaligned.
  - Misaligned result: out_err=1, out_data=0.
  - Imm modes ignore in_addr_lo and never set out_err.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Storage: output register (OR) plus skid register (SK), each with a valid bit.
- in_ready = !SK.valid, registered (no combinational path from out_ready).
- Per rising edge, with a = input transfer and d = output transfer:
  - OR empty or d, SK empty: a loads OR with the computed result; no a with d clears OR.valid.
  - OR full, no d, a: result goes into SK; in_ready drops next cycle.
  - SK full and d: SK moves to OR, SK clears, in_ready rises next cycle.
- Ordering: results leave in strict request order; no drops, no duplicates.
- Latency: 1 cycle from accepted input to out_valid when the output is not stalled.
- Stability: out_data/out_err/out_valid hold stable while out_valid & !out_ready.
- Reset values (asynchronous, any cycle, including mid-stall):
  - OR.valid=0, SK.valid=0, out_valid=0, out_data=0, out_err=0.
  - in_ready=1 from the first edge after reset deasserts.
  - In-flight data is discarded.
- Extension logic is purely combinational on the input side; only the OR/SK stage is sequential.

Decomposition:
- Shared package/header holds:
  - Mode constants EXT_ZERO..EXT_LW (3-bit).
  - AW derivation macro.
  - Misalign-check function.
- Sub-module ext_core: combinational mode decode, lane select, extension and error. Parametrised by DATA_WIDTH/IMM_WIDTH/BIG_ENDIAN.
- ext_pipe instantiates ext_core once and owns the OR/SK handshake logic.

Test Plan:
- Imm modes, DATA_WIDTH=32, in_data[15:0]=16'h8001, out_ready=1:
  - ZERO -> 32'h00008001.
  - SIGN -> 32'hFFFF8001.
  - LUI -> 32'h80010000.
  - Each appears exactly 1 cycle after the accept.
- Loads on word 32'h80FF7F01, BIG_ENDIAN=0:
  - LB addr 2 -> 32'hFFFFFFFF.
  - LBU addr 3 -> 32'h00000080.
  - LH addr 0 -> 32'h00007F01.
  - LHU addr 2 -> 32'h000080FF.
  - LW addr 0 -> 32'h80FF7F01.
  - BIG_ENDIAN=1, LBU addr 0 -> 32'h00000080.
- Misalignment: LH addr 1 and LW addr 2 -> out_err=1, out_data=0. SIGN with addr 3 -> out_err=0.
- Backpressure: stream 4 requests while holding out_ready=0 for 3 cycles:
  - OR and SK fill; in_ready=0 after the second accept.
  - Releasing out_ready delivers all 4 in order with no loss.
  - Output stays stable while stalled.
- Back-to-back throughput: in_valid=out_ready=1 for 16 cycles -> 16 results in 16 consecutive cycles; in_ready never drops.
- Reset: assert reset mid-stall with OR and SK full -> out_valid=0, out_data=0 immediately (async); in_ready=1 after release; the next request completes normally.
- DATA_WIDTH=64: LW addr 4 on 64'h8000_0000_0000_0001 -> 64'hFFFFFFFF80000000; LH addr 6 -> 64'hFFFFFFFFFFFF8000.
